regfile_hilo: RTL

Writeback-side consumer of the MEM/WB pipeline register. It holds the 32x32 general-purpose register file and the HI/LO special registers. It commits the wb_* write requests on the clock edge. It serves two combinational GPR read ports to decode and one HI/LO read port to execute, with write-through bypass so that a same-cycle writeback is visible to readers.

---
 rtl/regfile_hilo.sv | 88 ++++++++
 1 files changed

// File: rtl/regfile_hilo.sv
// Writeback-stage GPR file (32 x DATA_W, r0 hardwired to zero) plus HI/LO registers.
// Writes commit on the clock edge; reads are combinational, with same-cycle writeback bypass.
module regfile_hilo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_wReg,
  input  logic [ADDR_W-1:0] wb_wAddr,
  input  logic [DATA_W-1:0] wb_wData,
  input  logic              wb_wHiLo,
  input  logic [DATA_W-1:0] wb_hiData,
  input  logic [DATA_W-1:0] wb_loData,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic              gpr_we;

  // Writes to r0 are dropped here, so r0 stays zero in storage as well.
  assign gpr_we = wb_wReg && (wb_wAddr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (gpr_we) begin
        regs_q[wb_wAddr] <= wb_wData;
      end
      if (wb_wHiLo) begin
        hi_q <= wb_hiData;
        lo_q <= wb_loData;
      end
    end
  end

  always_comb begin
    rdata1 = '0;
    if (!rst && raddr1 != '0 && re1) begin
      if (wb_wReg && wb_wAddr == raddr1) begin
        rdata1 = wb_wData;
      end else begin
        rdata1 = regs_q[raddr1];
      end
    end
  end

  always_comb begin
    rdata2 = '0;
    if (!rst && raddr2 != '0 && re2) begin
      if (wb_wReg && wb_wAddr == raddr2) begin
        rdata2 = wb_wData;
      end else begin
        rdata2 = regs_q[raddr2];
      end
    end
  end

  always_comb begin
    hi_o = '0;
    lo_o = '0;
    if (!rst) begin
      if (wb_wHiLo) begin
        hi_o = wb_hiData;
        lo_o = wb_loData;
      end else begin
        hi_o = hi_q;
        lo_o = lo_q;
      end
    end
  end

endmodule
